synaptic_dispatch: RTL and testbench
====================================

Name: synaptic_dispatch

Overview:
- Consumer side of the fire FIFO: after each neuron-update time step it drains fired presynaptic tags from the FIFO head.
- For each tag, reads one weight per postsynaptic neuron from the synapse weight memory and issues weighted accumulate events to the neuron-input accumulator over a valid/ready handshake.
- Signals step completion to the time-step controller.

Parameters:
- numneurons, 2, neuron count; must satisfy numneurons <= 2**tagbits.
- tagbits, 1, width of a neuron tag.
- weightbits, 8, width of a synaptic weight, treated as two's complement.

Ports:
- clk  input  1  system clock, rising edge.
- syn_reset_n  input  1  synchronous active-low reset.
- start  input  1  one-cycle pulse beginning the synaptic phase; ignored unless idle.
- fifo_empty  input  1  fire FIFO empty flag.
- fifo_tag  input  tagbits  fire FIFO head tag, valid whenever fifo_empty=0.
- fifo_deq  output  1  pop request to the fire FIFO.
- w_rd  output  1  weight memory read strobe.
- w_addr  output  2*tagbits  {pre_tag, post_idx}.
- w_data  input  weightbits  read data, valid exactly one cycle after the w_rd cycle.
- acc_valid  output  1  accumulate event valid.
- acc_ready  input  1  accumulator accepts the event.
- acc_tag  output  tagbits  postsynaptic target tag.
- acc_weight  output  weightbits  weight to add.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when the phase completes.
- spike_count  output  tagbits+1  tags dequeued in the current or last phase.

Behaviour:
- Reset (syn_reset_n=0 at a rising edge) has priority over everything, including mid-phase:
  - state goes to IDLE;
  - fifo_deq, w_rd, acc_valid, busy and done all go to 0;
  - acc_tag, acc_weight, w_addr, spike_count and the internal pre/post registers go to 0.
- The FIFO is not touched by this block's reset.
- IDLE: start=1 clears spike_count and moves to DRAIN. start in any other state is ignored.
- DRAIN:
  - If fifo_empty=1, go to DONE.
  - Otherwise assert fifo_deq for this cycle only, latch pre=fifo_tag, set post=0, increment spike_count, and go to READ.
  - fifo_deq is combinational from state and fifo_empty. It is never high while fifo_empty=1 and never high outside DRAIN.
- READ: w_rd=1, w_addr={pre,post}; go to LATCH.
- LATCH: capture w_data into the acc_weight register at the end of the cycle; go to SEND.
- SEND:
  - acc_valid=1 with acc_tag=post and acc_weight held stable until acc_ready=1 at a rising edge.
  - On the handshake: if post==numneurons-1, go to DRAIN; else post=post+1 and go to READ.
  - acc_valid drops the cycle after the handshake.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Timing with acc_ready held high:
  - start sampled at edge k with the FIFO empty: DRAIN in cycle k+1, done in cycle k+2.
  - Each tag costs 1 + 3*numneurons cycles.
- post counts modulo numneurons and must never reach numneurons. spike_count saturates at 2**(tagbits+1)-1.
- Self-synapses (pre==post) are dispatched like any other; a zero weight in memory means no connection.
- The FIFO may be enqueued while this block is in the middle of a phase. Tags seen as non-empty in DRAIN are consumed in the same phase.

Optional Feature:
- Macro: SKIP_ZERO_EN.
- Defined: in LATCH, if w_data==0, skip SEND. Go to READ with post+1, or to DRAIN if post==numneurons-1. Zero-weight events never reach the accumulator.
- Undefined: every (pre, post) pair produces one accumulate event, including weight 0.

Test Plan:
- Reset, empty FIFO, start pulse -> done high exactly 2 cycles after start, spike_count=0, fifo_deq, w_rd and acc_valid never high.
- numneurons=4, tagbits=2, FIFO holds tag 2, weights row 2 = {5,0,-3,7}, acc_ready=1 -> events (0,5),(1,0),(2,-3),(3,7) in order, one fifo_deq, spike_count=1, done 15 cycles after start.
- FIFO holds tags 1 then 3 -> all events for pre=1 precede those for pre=3, w_addr sequence 4,5,6,7,12,13,14,15, spike_count=2.
- acc_ready held low 5 cycles during the first SEND -> acc_valid, acc_tag and acc_weight stable throughout, no extra w_rd, sequence resumes unchanged.
- syn_reset_n low during SEND of the second event -> next cycle in IDLE, busy=0, acc_valid=0; a subsequent start re-drains the remaining FIFO contents normally.
- SKIP_ZERO_EN defined, row {5,0,-3,7} -> only 3 events, (1,0) absent, done 1 cycle earlier than the undefined build.

Source files
------------

// File: rtl/synaptic_dispatch_if.sv
// synaptic_dispatch_if: fire FIFO head, weight memory port and accumulator handshake
interface synaptic_dispatch_if #(
  parameter int tagbits    = 1,
  parameter int weightbits = 8
);
  logic                    fifo_empty;
  logic [tagbits-1:0]      fifo_tag;
  logic                    fifo_deq;
  logic                    w_rd;
  logic [2*tagbits-1:0]    w_addr;
  logic [weightbits-1:0]   w_data;
  logic                    acc_valid;
  logic                    acc_ready;
  logic [tagbits-1:0]      acc_tag;
  logic [weightbits-1:0]   acc_weight;
  modport master (
    input  fifo_empty, fifo_tag, w_data, acc_ready,
    output fifo_deq, w_rd, w_addr, acc_valid, acc_tag, acc_weight
  );
  modport slave (
    output fifo_empty, fifo_tag, w_data, acc_ready,
    input  fifo_deq, w_rd, w_addr, acc_valid, acc_tag, acc_weight
  );
endinterface

// File: rtl/synaptic_dispatch.sv
// synaptic_dispatch: drains fired tags and issues one weighted accumulate per postsynaptic neuron.
// Optional SKIP_ZERO_EN: zero weights are read but never sent to the accumulator.
module synaptic_dispatch #(
  parameter int numneurons = 2,
  parameter int tagbits    = 1,
  parameter int weightbits = 8
) (
  input  logic                clk,
  input  logic                syn_reset_n,
  input  logic                start,
  synaptic_dispatch_if.master bus,
  output logic                busy,
  output logic                done,
  output logic [tagbits:0]    spike_count
);
  typedef enum logic [2:0] {IDLE, DRAIN, READ, LATCH, SEND, DONE} state_t;
  localparam logic [tagbits-1:0] LAST = tagbits'(numneurons - 1);
  state_t                state_q;
  logic [tagbits-1:0]    pre_q, post_q, acc_tag_q;
  logic [2*tagbits-1:0]  w_addr_q;
  logic [weightbits-1:0] acc_weight_q;
  logic [tagbits:0]      spike_count_q;
  logic                  w_rd_q, acc_valid_q, busy_q, done_q;
  logic [tagbits-1:0]    post_inc;
  logic                  last;
  assign post_inc = post_q + 1'b1;
  assign last     = post_q == LAST;
  // The pop must land in the same cycle the head tag is latched.
  assign bus.fifo_deq   = (state_q == DRAIN) && !bus.fifo_empty;
  assign bus.w_rd       = w_rd_q;
  assign bus.w_addr     = w_addr_q;
  assign bus.acc_valid  = acc_valid_q;
  assign bus.acc_tag    = acc_tag_q;
  assign bus.acc_weight = acc_weight_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign spike_count    = spike_count_q;
  always_ff @(posedge clk) begin
    if (!syn_reset_n) begin
      state_q       <= IDLE;
      pre_q         <= '0;
      post_q        <= '0;
      acc_tag_q     <= '0;
      acc_weight_q  <= '0;
      w_addr_q      <= '0;
      spike_count_q <= '0;
      w_rd_q        <= 1'b0;
      acc_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      w_rd_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          spike_count_q <= '0;
          busy_q        <= 1'b1;
          state_q       <= DRAIN;
        end
        DRAIN: if (bus.fifo_empty) begin
          done_q  <= 1'b1;
          state_q <= DONE;
        end else begin
          pre_q         <= bus.fifo_tag;
          post_q        <= '0;
          w_addr_q      <= {bus.fifo_tag, {tagbits{1'b0}}};
          w_rd_q        <= 1'b1;
          spike_count_q <= spike_count_q + {{tagbits{1'b0}}, ~&spike_count_q};
          state_q       <= READ;
        end
        READ: state_q <= LATCH;
        LATCH: begin
          acc_weight_q <= bus.w_data;
`ifdef SKIP_ZERO_EN
          if (bus.w_data == '0) begin
            if (last) state_q <= DRAIN;
            else begin
              post_q   <= post_inc;
              w_addr_q <= {pre_q, post_inc};
              w_rd_q   <= 1'b1;
              state_q  <= READ;
            end
          end else begin
            acc_valid_q <= 1'b1;
            acc_tag_q   <= post_q;
            state_q     <= SEND;
          end
`else
          acc_valid_q <= 1'b1;
          acc_tag_q   <= post_q;
          state_q     <= SEND;
`endif
        end
        SEND: if (bus.acc_ready) begin
          acc_valid_q <= 1'b0;
          if (last) state_q <= DRAIN;
          else begin
            post_q   <= post_inc;
            w_addr_q <= {pre_q, post_inc};
            w_rd_q   <= 1'b1;
            state_q  <= READ;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_synaptic_dispatch.sv
// tb_synaptic_dispatch: scoreboard bench with FIFO, weight memory and accumulator models
module tb_synaptic_dispatch;
  localparam int N = 4, TB = 2, WB = 8;
`ifdef SKIP_ZERO_EN
  localparam int ONE_LEN = 14;
`else
  localparam int ONE_LEN = 15;
`endif
  logic clk = 0, syn_reset_n = 0, start = 0;
  logic busy, done;
  logic [TB:0] spike_count;
  synaptic_dispatch_if #(.tagbits(TB), .weightbits(WB)) bus();
  synaptic_dispatch #(.numneurons(N), .tagbits(TB), .weightbits(WB)) dut (
    .clk(clk), .syn_reset_n(syn_reset_n), .start(start), .bus(bus),
    .busy(busy), .done(done), .spike_count(spike_count)
  );
  always #5 clk = ~clk;
  logic [WB-1:0]    mem [N*N];
  logic [TB-1:0]    ftags [16];
  logic [TB+WB-1:0] sb [$];
  logic [2*TB-1:0]  aq [$];
  int pop_cnt = 0, fwr = 0;
  int checks = 0, errors = 0;
  int deq_cnt, rd_cnt, ev_cnt, stall_left = 0;
  assign bus.fifo_empty = pop_cnt == fwr;
  assign bus.fifo_tag   = ftags[pop_cnt[3:0]];
  always @(posedge clk) begin
    if (bus.fifo_deq) pop_cnt <= pop_cnt + 1;
    if (bus.w_rd) bus.w_data <= mem[bus.w_addr];
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model(input logic [TB-1:0] t, output int cost);
    logic [WB-1:0] w;
    cost = 1 + 3*N;
    for (int p = 0; p < N; p++) begin
      w = mem[int'(t)*N + p];
      aq.push_back({t, TB'(p)});
`ifdef SKIP_ZERO_EN
      if (w == '0) cost--;
      else sb.push_back({TB'(p), w});
`else
      sb.push_back({TB'(p), w});
`endif
    end
  endtask
  task automatic push(input logic [TB-1:0] t, inout int len);
    int c;
    ftags[fwr[3:0]] = t;
    fwr++;
    model(t, c);
    len += c;
  endtask
  task automatic tick();
    logic [TB+WB-1:0] e;
    @(negedge clk);
    if (bus.fifo_deq) begin
      deq_cnt++;
      chk("deq_nonempty", bus.fifo_empty, 0);
    end
    if (bus.w_rd) begin
      rd_cnt++;
      chk("rd_expected", aq.size() != 0, 1);
      if (aq.size() != 0) chk("w_addr", bus.w_addr, aq.pop_front());
    end
    if (bus.acc_valid) begin
      chk("ev_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb[0];
        chk("acc_tag", bus.acc_tag, e[TB+WB-1:WB]);
        chk("acc_weight", bus.acc_weight, e[WB-1:0]);
      end
      bus.acc_ready = stall_left == 0;
      if (stall_left > 0) stall_left--;
      if (bus.acc_ready) begin
        ev_cnt++;
        if (sb.size() != 0) void'(sb.pop_front());
      end
    end else bus.acc_ready = 1'b1;
  endtask
  task automatic run(input string nm, input int exp_len, input int exp_spk);
    int n = 0;
    bit got = 0;
    deq_cnt = 0; rd_cnt = 0; ev_cnt = 0;
    start = 1'b1;
    while (!got && n < 500) begin
      tick();
      start = 1'b0;
      n++;
      got = done;
    end
    chk({nm, "_len"}, got ? n : 0, exp_len);
    tick();
    chk({nm, "_idle"}, busy, 0);
    chk({nm, "_spikes"}, spike_count, exp_spk);
    chk({nm, "_sb_empty"}, sb.size(), 0);
    chk({nm, "_rd_empty"}, aq.size(), 0);
  endtask
  initial begin
    int len;
    bit found;
    for (int i = 0; i < N*N; i++) mem[i] = 8'($urandom_range(1, 255));
    mem[8] = 8'd5; mem[9] = 8'd0; mem[10] = 8'hFD; mem[11] = 8'd7;
    bus.acc_ready = 1'b1;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", bus.acc_valid, 0);
    chk("rst_rd", bus.w_rd, 0);
    chk("rst_spikes", spike_count, 0);
    chk("rst_addr", bus.w_addr, 0);
    chk("rst_acc_tag", bus.acc_tag, 0);
    syn_reset_n = 1'b1;
    tick();
    run("empty", 2, 0);
    chk("empty_deq", deq_cnt, 0);
    chk("empty_rd", rd_cnt, 0);
    chk("empty_ev", ev_cnt, 0);
    len = 2;
    push(2, len);
    run("one", ONE_LEN, 1);
    chk("one_model_len", len, ONE_LEN);
    chk("one_deq", deq_cnt, 1);
`ifdef SKIP_ZERO_EN
    chk("one_ev", ev_cnt, 3);
`else
    chk("one_ev", ev_cnt, 4);
`endif
    len = 2;
    push(1, len);
    push(3, len);
    run("two", len, 2);
    chk("two_rd", rd_cnt, 8);
    len = 2 + 5;
    push(2, len);
    stall_left = 5;
    run("stall", len, 1);
    chk("stall_rd", rd_cnt, 4);
    len = 0;
    push(1, len);
    push(3, len);
    deq_cnt = 0; rd_cnt = 0; ev_cnt = 0;
    found = 0;
    start = 1'b1;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      start = 1'b0;
      found = bus.acc_valid && bus.acc_tag == 1;
    end
    chk("rst_mid_found", found, 1);
    syn_reset_n = 1'b0;
    tick();
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_valid", bus.acc_valid, 0);
    chk("rst_mid_spikes", spike_count, 0);
    syn_reset_n = 1'b1;
    sb.delete();
    aq.delete();
    len = 2;
    for (int i = pop_cnt; i < fwr; i++) begin
      int c;
      model(ftags[i[3:0]], c);
      len += c;
    end
    chk("rst_mid_left", fwr - pop_cnt, 1);
    run("redrain", len, 1);
    len = 2;
    for (int i = 0; i < 8; i++) push(TB'(i), len);
    run("sat", len, 7);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
